axi_mem_responder: RTL and testbench

// AXI4 slave (responder) that terminates the DDR-side AXI master: accepts INCR write/read bursts

---
 rtl/mig_axi_pkg.sv | 29 ++
 rtl/axi_resp_ram.sv | 43 ++++
 rtl/axi_mem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_axi_pkg.sv
// rtl/mig_axi_pkg.sv - AXI constants, FSM state encodings and sizing helper for the memory responder
package mig_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  function automatic int clogb2(input int value);
    int v;
    v = value - 1;
    clogb2 = 0;
    while (v > 0) begin
      clogb2 = clogb2 + 1;
      v = v >> 1;
    end
  endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// rtl/axi_resp_ram.sv - simple dual-port RAM, byte-enabled write, registered read with read enable
module axi_resp_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 1024,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [IDX_WIDTH-1:0]    i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_re,
  input  logic [IDX_WIDTH-1:0]    i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array is never reset so contents survive rst_n pulses.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Holding the output register while i_re=0 keeps rdata stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 INCR-burst slave backed by on-chip RAM, one transaction per direction
module axi_mem_responder #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic [2:0]                    axi_awsize,
  input  logic [1:0]                    axi_awburst,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wlast,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic [2:0]                    axi_arsize,
  input  logic [1:0]                    axi_arburst,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);

  import mig_axi_pkg::*;

  localparam int         BYTES     = C_AXI_DATA_WIDTH / 8;
  localparam int         BSHIFT    = clogb2(BYTES);
  localparam int         IDXW      = clogb2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(BSHIFT);

  // Write path state
  wr_state_t                 r_wr_state;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic [C_AXI_ID_WIDTH-1:0] r_bid;
  logic [IDXW-1:0]           r_widx;
  logic [7:0]                r_wlen;
  logic [7:0]                r_wcnt;
  logic                      r_werr;

  // Read path state
  rd_state_t                 r_rd_state;
  logic                      r_arready;
  logic                      r_rvalid;
  logic                      r_rlast;
  logic [1:0]                r_rresp;
  logic [C_AXI_ID_WIDTH-1:0] r_rid;
  logic [IDXW-1:0]           r_ridx;
  logic [7:0]                r_rlen;
  logic [7:0]                r_rcnt;

  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_w_final;
  logic                        w_ar_hs;
  logic                        w_ren;
  logic [IDXW-1:0]             w_awidx;
  logic [IDXW-1:0]             w_aridx;
  logic [C_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                        w_unused_addr;

  assign w_awidx   = axi_awaddr[BSHIFT +: IDXW];
  assign w_aridx   = axi_araddr[BSHIFT +: IDXW];
  assign w_aw_hs   = r_awready & axi_awvalid;
  assign w_w_hs    = r_wready & axi_wvalid;
  assign w_w_final = (r_wcnt == r_wlen);
  assign w_ar_hs   = r_arready & axi_arvalid;

  assign w_unused_addr = ^{axi_awaddr[BSHIFT-1:0], axi_awaddr[C_AXI_ADDR_WIDTH-1:BSHIFT+IDXW],
                           axi_araddr[BSHIFT-1:0], axi_araddr[C_AXI_ADDR_WIDTH-1:BSHIFT+IDXW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= AXI_RESP_OKAY;
      r_bid      <= '0;
      r_widx     <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_werr     <= 1'b0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_bid      <= axi_awid;
            r_widx     <= w_awidx;
            r_wlen     <= axi_awlen;
            r_wcnt     <= 8'd0;
            r_werr     <= (axi_awburst != AXI_BURST_INCR) || (axi_awsize != FULL_SIZE);
            r_wr_state <= WR_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_w_hs) begin
            if (w_w_final) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_bresp    <= (r_werr || !axi_wlast) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              r_wr_state <= WR_RESP;
            end else begin
              r_wcnt <= r_wcnt + 8'd1;
              r_widx <= r_widx + IDXW'(1);
              if (axi_wlast) begin
                r_werr <= 1'b1;
              end
            end
          end
        end
        WR_RESP: begin
          if (axi_bready) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= AXI_RESP_OKAY;
            r_awready  <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // RAM is read when the first beat is fetched and whenever a non-final beat is accepted.
  assign w_ren = (r_rd_state == RD_DATA) && (!r_rvalid || (axi_rready && !r_rlast));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= AXI_RESP_OKAY;
      r_rid      <= '0;
      r_ridx     <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_arready  <= 1'b0;
            r_rid      <= axi_arid;
            r_ridx     <= w_aridx;
            r_rlen     <= axi_arlen;
            r_rcnt     <= 8'd0;
            r_rresp    <= ((axi_arburst != AXI_BURST_INCR) || (axi_arsize != FULL_SIZE))
                          ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_rd_state <= RD_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_rlen == 8'd0);
            r_ridx   <= r_ridx + IDXW'(1);
          end else if (axi_rready) begin
            if (r_rlast) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_arready  <= 1'b1;
              r_rd_state <= RD_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_ridx  <= r_ridx + IDXW'(1);
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  axi_resp_ram #(
    .DATA_WIDTH (C_AXI_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_WIDTH  (IDXW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_w_hs),
    .i_waddr (r_widx),
    .i_wdata (axi_wdata),
    .i_wstrb (axi_wstrb),
    .i_re    (w_ren),
    .i_raddr (r_ridx),
    .o_rdata (w_rdata)
  );

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_bid     = r_bid;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rlast   = r_rlast;
  assign axi_rresp   = r_rresp;
  assign axi_rid     = r_rid;
  assign axi_rdata   = w_rdata;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed self-checking bench for axi_mem_responder
module tb_axi_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   axi_awid = '0;
  logic [63:0]  axi_awaddr = '0;
  logic [7:0]   axi_awlen = '0;
  logic [2:0]   axi_awsize = 3'd5;
  logic [1:0]   axi_awburst = 2'b01;
  logic         axi_awvalid = 1'b0;
  logic         axi_awready;
  logic [255:0] axi_wdata = '0;
  logic [31:0]  axi_wstrb = '0;
  logic         axi_wlast = 1'b0;
  logic         axi_wvalid = 1'b0;
  logic         axi_wready;
  logic [3:0]   axi_bid;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready = 1'b1;
  logic [3:0]   axi_arid = '0;
  logic [63:0]  axi_araddr = '0;
  logic [7:0]   axi_arlen = '0;
  logic [2:0]   axi_arsize = 3'd5;
  logic [1:0]   axi_arburst = 2'b01;
  logic         axi_arvalid = 1'b0;
  logic         axi_arready;
  logic [3:0]   axi_rid;
  logic [255:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rvalid;
  logic         axi_rready = 1'b1;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int checks = 0;
  int fails  = 0;
  int tmo    = 0;

  logic [255:0] cap_data [64];
  logic         cap_last [64];
  logic [1:0]   cap_resp [64];
  logic [3:0]   cap_id   [64];
  int           cap_n;
  int           stall_bad;
  logic [1:0]   got_bresp;
  logic [3:0]   got_bid;

  function automatic logic [255:0] pat(input logic [31:0] seed, input int k);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = seed ^ (32'(k) << 8) ^ (32'(i) * 32'h0101_0101);
    return r;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int wlast_at,
                          input logic [31:0] strb, input logic [31:0] seed);
    int n;
    @(negedge clk);
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awsize = size;
    axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo++;
    @(negedge clk);
    axi_awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      axi_wdata = pat(seed, k); axi_wstrb = strb; axi_wlast = (k == wlast_at); axi_wvalid = 1'b1;
      n = 0;
      while (!axi_wready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) tmo++;
      @(negedge clk);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    n = 0;
    while (!axi_bvalid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo++;
    got_bresp = axi_bresp; got_bid = axi_bid;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    int n;
    bit held;
    logic [255:0] hd;
    logic hl;
    cap_n = 0; stall_bad = 0; held = 0; hd = '0; hl = 1'b0;
    @(negedge clk);
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arsize = 3'd5;
    axi_arvalid = 1'b1; axi_rready = 1'b1;
    n = 0;
    while (!axi_arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo++;
    @(negedge clk);
    axi_arvalid = 1'b0;
    n = 0;
    while (cap_n <= int'(len) && n < 500) begin
      if (axi_rvalid && axi_rready) begin
        cap_data[cap_n] = axi_rdata; cap_last[cap_n] = axi_rlast;
        cap_resp[cap_n] = axi_rresp; cap_id[cap_n] = axi_rid;
        cap_n++;
      end else if (axi_rvalid) begin
        held = 1; hd = axi_rdata; hl = axi_rlast;
      end
      @(negedge clk);
      n++;
      if (held && (axi_rdata !== hd || axi_rlast !== hl || axi_rvalid !== 1'b1)) stall_bad++;
      held = 0;
      if (toggle) axi_rready = ~axi_rready;
    end
    if (n >= 500) tmo++;
    axi_rready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (axi_awready !== 1'b0) begin fails++; $display("FAIL reset_awready got %b exp 0", axi_awready); end
    checks++; if (axi_arready !== 1'b0) begin fails++; $display("FAIL reset_arready got %b exp 0", axi_arready); end
    checks++; if ({axi_wready, axi_bvalid, axi_rvalid, axi_rlast} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {axi_wready, axi_bvalid, axi_rvalid, axi_rlast}); end
    checks++; if ({axi_bresp, axi_rresp, axi_bid, axi_rid} !== 12'h0) begin fails++; $display("FAIL reset_resp_ids got %h exp 000", {axi_bresp, axi_rresp, axi_bid, axi_rid}); end
    checks++; if (axi_rdata !== 256'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", axi_rdata); end
    rst_n = 1'b1;
    #1;
    checks++; if (axi_awready !== 1'b0) begin fails++; $display("FAIL awready_before_edge got %b exp 0", axi_awready); end
    @(negedge clk);
    checks++; if (axi_awready !== 1'b1) begin fails++; $display("FAIL awready_after_edge got %b exp 1", axi_awready); end
    checks++; if (axi_arready !== 1'b1) begin fails++; $display("FAIL arready_after_edge got %b exp 1", axi_arready); end
  endtask

  task automatic test_first_read_latency;
    axi_arid = 4'h3; axi_araddr = 64'h0; axi_arlen = 8'd0; axi_arburst = 2'b01; axi_arsize = 3'd5;
    axi_arvalid = 1'b1; axi_rready = 1'b1;
    @(negedge clk);
    axi_arvalid = 1'b0;
    checks++; if (axi_rvalid !== 1'b0) begin fails++; $display("FAIL lat_edge1_rvalid got %b exp 0", axi_rvalid); end
    @(negedge clk);
    checks++; if (axi_rvalid !== 1'b1) begin fails++; $display("FAIL lat_edge2_rvalid got %b exp 1", axi_rvalid); end
    checks++; if (axi_rlast !== 1'b1) begin fails++; $display("FAIL lat_rlast got %b exp 1", axi_rlast); end
    checks++; if (axi_rid !== 4'h3) begin fails++; $display("FAIL lat_rid got %h exp 3", axi_rid); end
    @(negedge clk);
    checks++; if ({axi_rvalid, axi_arready} !== 2'b01) begin fails++; $display("FAIL lat_after_last got %b exp 01", {axi_rvalid, axi_arready}); end
  endtask

  task automatic test_burst;
    do_write(4'h5, 64'h40, 8'd7, 2'b01, 3'd5, 7, 32'hFFFF_FFFF, 32'hA5A5_1000);
    checks++; if (got_bresp !== 2'b00) begin fails++; $display("FAIL burst_bresp got %b exp 00", got_bresp); end
    checks++; if (got_bid !== 4'h5) begin fails++; $display("FAIL burst_bid got %h exp 5", got_bid); end
    checks++; if (axi_awready !== 1'b1) begin fails++; $display("FAIL burst_awready_back got %b exp 1", axi_awready); end
    do_read(4'h9, 64'h40, 8'd7, 2'b01, 1'b0);
    checks++; if (cap_n !== 8) begin fails++; $display("FAIL burst_beats got %0d exp 8", cap_n); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (cap_data[k] !== pat(32'hA5A5_1000, k)) begin fails++; $display("FAIL burst_data[%0d] got %h exp %h", k, cap_data[k], pat(32'hA5A5_1000, k)); end
      checks++; if (cap_last[k] !== (k == 7)) begin fails++; $display("FAIL burst_rlast[%0d] got %b exp %b", k, cap_last[k], k == 7); end
      checks++; if ({cap_id[k], cap_resp[k]} !== {4'h9, 2'b00}) begin fails++; $display("FAIL burst_rid_rresp[%0d] got %h/%b exp 9/00", k, cap_id[k], cap_resp[k]); end
    end
    checks++; if ({axi_rvalid, axi_arready} !== 2'b01) begin fails++; $display("FAIL burst_read_end got %b exp 01", {axi_rvalid, axi_arready}); end
  endtask

  task automatic test_strobe;
    logic [255:0] full, part, exp;
    full = pat(32'h1111_2222, 0);
    part = pat(32'h9999_8888, 0);
    exp  = {full[255:32], part[31:0]};
    do_write(4'h1, 64'h400, 8'd0, 2'b01, 3'd5, 0, 32'hFFFF_FFFF, 32'h1111_2222);
    do_write(4'h2, 64'h400, 8'd0, 2'b01, 3'd5, 0, 32'h0000_000F, 32'h9999_8888);
    checks++; if (got_bresp !== 2'b00) begin fails++; $display("FAIL strobe_bresp got %b exp 00", got_bresp); end
    do_read(4'h2, 64'h400, 8'd0, 2'b01, 1'b0);
    checks++; if (cap_data[0] !== exp) begin fails++; $display("FAIL strobe_data got %h exp %h", cap_data[0], exp); end
  endtask

  task automatic test_backpressure;
    do_write(4'h7, 64'hC80, 8'd15, 2'b01, 3'd5, 15, 32'hFFFF_FFFF, 32'h0BAD_F00D);
    do_read(4'hC, 64'hC80, 8'd15, 2'b01, 1'b1);
    checks++; if (cap_n !== 16) begin fails++; $display("FAIL bp_beats got %0d exp 16", cap_n); end
    checks++; if (stall_bad !== 0) begin fails++; $display("FAIL bp_stall_changes got %0d exp 0", stall_bad); end
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_data[k] !== pat(32'h0BAD_F00D, k)) begin fails++; $display("FAIL bp_data[%0d] got %h exp %h", k, cap_data[k], pat(32'h0BAD_F00D, k)); end
    end
    checks++; if ({cap_last[14], cap_last[15]} !== 2'b01) begin fails++; $display("FAIL bp_rlast got %b exp 01", {cap_last[14], cap_last[15]}); end
  endtask

  task automatic test_wrap;
    do_write(4'h4, 64'h7FC0, 8'd3, 2'b01, 3'd5, 3, 32'hFFFF_FFFF, 32'hC0DE_0000);
    checks++; if (got_bresp !== 2'b00) begin fails++; $display("FAIL wrap_bresp got %b exp 00", got_bresp); end
    do_read(4'h4, 64'h7FC0, 8'd3, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (cap_data[k] !== pat(32'hC0DE_0000, k)) begin fails++; $display("FAIL wrap_data[%0d] got %h exp %h", k, cap_data[k], pat(32'hC0DE_0000, k)); end
    end
    do_read(4'h4, 64'h0, 8'd0, 2'b01, 1'b0);
    checks++; if (cap_data[0] !== pat(32'hC0DE_0000, 2)) begin fails++; $display("FAIL wrap_word0 got %h exp %h", cap_data[0], pat(32'hC0DE_0000, 2)); end
    do_read(4'h4, 64'h20, 8'd0, 2'b01, 1'b0);
    checks++; if (cap_data[0] !== pat(32'hC0DE_0000, 3)) begin fails++; $display("FAIL wrap_word1 got %h exp %h", cap_data[0], pat(32'hC0DE_0000, 3)); end
  endtask

  task automatic test_errors;
    do_write(4'h6, 64'h2000, 8'd3, 2'b00, 3'd5, 3, 32'hFFFF_FFFF, 32'hE000_0001);
    checks++; if (got_bresp !== 2'b10) begin fails++; $display("FAIL err_fixed_bresp got %b exp 10", got_bresp); end
    checks++; if (got_bid !== 4'h6) begin fails++; $display("FAIL err_fixed_bid got %h exp 6", got_bid); end
    do_write(4'h6, 64'h2100, 8'd3, 2'b01, 3'd5, 2, 32'hFFFF_FFFF, 32'hE000_0002);
    checks++; if (got_bresp !== 2'b10) begin fails++; $display("FAIL err_early_wlast_bresp got %b exp 10", got_bresp); end
    do_write(4'h6, 64'h2200, 8'd1, 2'b01, 3'd4, 1, 32'hFFFF_FFFF, 32'hE000_0003);
    checks++; if (got_bresp !== 2'b10) begin fails++; $display("FAIL err_size_bresp got %b exp 10", got_bresp); end
    do_write(4'h6, 64'h2300, 8'd0, 2'b01, 3'd5, 0, 32'hFFFF_FFFF, 32'hE000_0004);
    checks++; if (got_bresp !== 2'b00) begin fails++; $display("FAIL err_cleared_bresp got %b exp 00", got_bresp); end
    do_read(4'hA, 64'h2000, 8'd3, 2'b01, 1'b0);
    checks++; if (cap_data[3] !== pat(32'hE000_0001, 3)) begin fails++; $display("FAIL err_write_persists got %h exp %h", cap_data[3], pat(32'hE000_0001, 3)); end
    checks++; if (cap_resp[0] !== 2'b00) begin fails++; $display("FAIL err_incr_rresp got %b exp 00", cap_resp[0]); end
    do_read(4'hB, 64'h2100, 8'd1, 2'b00, 1'b0);
    checks++; if ({cap_resp[0], cap_resp[1]} !== 4'b1010) begin fails++; $display("FAIL err_rresp got %b exp 1010", {cap_resp[0], cap_resp[1]}); end
    checks++; if (cap_data[1] !== pat(32'hE000_0002, 1)) begin fails++; $display("FAIL err_rdata got %h exp %h", cap_data[1], pat(32'hE000_0002, 1)); end
  endtask

  task automatic test_reset_mid_read;
    int n;
    @(negedge clk);
    axi_arid = 4'hD; axi_araddr = 64'h40; axi_arlen = 8'd15; axi_arburst = 2'b01; axi_arsize = 3'd5;
    axi_arvalid = 1'b1; axi_rready = 1'b0;
    n = 0;
    while (!axi_arready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    axi_arvalid = 1'b0;
    while (!axi_rvalid && n < 400) begin @(negedge clk); n++; end
    checks++; if (n >= 400) begin fails++; $display("FAIL midrst_wait_rvalid got timeout exp rvalid"); end
    rst_n = 1'b0;
    #1;
    checks++; if ({axi_rvalid, axi_rlast, axi_arready} !== 3'b000) begin fails++; $display("FAIL midrst_outputs got %b exp 000", {axi_rvalid, axi_rlast, axi_arready}); end
    checks++; if (axi_rdata !== 256'h0) begin fails++; $display("FAIL midrst_rdata got %h exp 0", axi_rdata); end
    @(negedge clk);
    rst_n = 1'b1; axi_rready = 1'b1;
    #1;
    checks++; if (axi_arready !== 1'b0) begin fails++; $display("FAIL midrst_arready_release got %b exp 0", axi_arready); end
    @(negedge clk);
    checks++; if (axi_arready !== 1'b1) begin fails++; $display("FAIL midrst_arready_edge got %b exp 1", axi_arready); end
    do_read(4'hE, 64'h40, 8'd7, 2'b01, 1'b0);
    checks++; if (cap_data[5] !== pat(32'hA5A5_1000, 5)) begin fails++; $display("FAIL midrst_mem_persists got %h exp %h", cap_data[5], pat(32'hA5A5_1000, 5)); end
  endtask

  initial begin
    test_reset();
    test_first_read_latency();
    test_burst();
    test_strobe();
    test_backpressure();
    test_wrap();
    test_errors();
    test_reset_mid_read();
    checks++; if (tmo !== 0) begin fails++; $display("FAIL handshake_timeouts got %0d exp 0", tmo); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
